// File: rtl/tile_priority_mixer_pkg.sv
// Shared video definitions for the System86 tile/sprite mixing path.
// Contents: default transparent DT code, bus widths, the {PR,CL,DT} pixel tuple,
// the winner-source encoding and an opacity helper.
package system86_video_pkg;

  localparam int unsigned PAL_ADDR_W = 11;
  localparam int unsigned COLOR_W    = 8;
  localparam int unsigned PRI_W      = 3;
  localparam int unsigned DT_W       = 3;

  localparam logic [DT_W-1:0] DT_TRANSPARENT_DEF = 3'd7;

  typedef struct packed {
    logic [PRI_W-1:0]   pr;
    logic [COLOR_W-1:0] cl;
    logic [DT_W-1:0]    dt;
  } tile_px_t;

  typedef enum logic [1:0] {
    SRC_A,
    SRC_B,
    SRC_BG
  } win_src_e;

  function automatic logic px_opaque(input tile_px_t px, input logic [DT_W-1:0] dt_transp);
    return px.dt != dt_transp;
  endfunction

endpackage

// File: rtl/tile_priority_mixer_if.sv
// Pixel-side bus of tile_priority_mixer: two CUS43 layer tuples, blanking,
// palette PROM address/data, background colour write port and mixed output.
// master: the surrounding video logic (drives layers, blanks, PAL_Q, BG write)
// slave : the mixer (drives PAL_ADDR, DOT, PRO)
interface tile_priority_mixer_if;
  import system86_video_pkg::*;

  logic                  HBLANK;
  logic                  VBLANK;
  logic [PRI_W-1:0]      A_PR;
  logic [COLOR_W-1:0]    A_CL;
  logic [DT_W-1:0]       A_DT;
  logic [PRI_W-1:0]      B_PR;
  logic [COLOR_W-1:0]    B_CL;
  logic [DT_W-1:0]       B_DT;
  logic [PAL_ADDR_W-1:0] PAL_ADDR;
  logic [COLOR_W-1:0]    PAL_Q;
  logic                  BG_WE;
  logic [COLOR_W-1:0]    BG_D;
  logic [COLOR_W-1:0]    DOT;
  logic [PRI_W-1:0]      PRO;

  modport master (
    output HBLANK, VBLANK, A_PR, A_CL, A_DT, B_PR, B_CL, B_DT, PAL_Q, BG_WE, BG_D,
    input  PAL_ADDR, DOT, PRO
  );

  modport slave (
    input  HBLANK, VBLANK, A_PR, A_CL, A_DT, B_PR, B_CL, B_DT, PAL_Q, BG_WE, BG_D,
    output PAL_ADDR, DOT, PRO
  );

endinterface

// File: rtl/tile_priority_mixer_select.sv
// tile_layer_select: combinational winner pick between two {PR,CL,DT} tuples.
// Ports: i_a, i_b       input tuples (A wins ties)
//        o_sel_bg       neither tuple opaque
//        o_win_pr/cl/dt winning tuple fields (A's fields when o_sel_bg)
module tile_layer_select
  import system86_video_pkg::*;
#(
  parameter logic [DT_W-1:0] DT_TRANSPARENT = DT_TRANSPARENT_DEF
) (
  input  tile_px_t           i_a,
  input  tile_px_t           i_b,
  output logic               o_sel_bg,
  output logic [PRI_W-1:0]   o_win_pr,
  output logic [COLOR_W-1:0] o_win_cl,
  output logic [DT_W-1:0]    o_win_dt
);

  logic     w_a_op;
  logic     w_b_op;
  win_src_e w_src;

  assign w_a_op = px_opaque(i_a, DT_TRANSPARENT);
  assign w_b_op = px_opaque(i_b, DT_TRANSPARENT);

  always_comb begin
    w_src = SRC_BG;
    if (w_a_op && w_b_op) w_src = (i_b.pr > i_a.pr) ? SRC_B : SRC_A;
    else if (w_a_op)      w_src = SRC_A;
    else if (w_b_op)      w_src = SRC_B;
  end

  assign o_sel_bg = (w_src == SRC_BG);
  assign o_win_pr = (w_src == SRC_B) ? i_b.pr : i_a.pr;
  assign o_win_cl = (w_src == SRC_B) ? i_b.cl : i_a.cl;
  assign o_win_dt = (w_src == SRC_B) ? i_b.dt : i_a.dt;

endmodule

// File: rtl/tile_priority_mixer.sv
// tile_priority_mixer: merges tile layers A/B into one colour index for the CLUT.
// Stage 1 registers the palette address and winner info, stage 2 registers
// DOT/PRO from PAL_Q, the background colour, or the blank value.
// Ports: CLK_6M  pixel clock
//        rst     synchronous active-low reset
//        bus     tile_priority_mixer_if.slave (layers, blanks, PROM, BG write, DOT/PRO)
module tile_priority_mixer
  import system86_video_pkg::*;
#(
  parameter logic [DT_W-1:0]    DT_TRANSPARENT = DT_TRANSPARENT_DEF,
  parameter logic [COLOR_W-1:0] BLANK_DOT      = 8'h00
) (
  input  logic                 CLK_6M,
  input  logic                 rst,
  tile_priority_mixer_if.slave bus
);

  tile_px_t              w_a;
  tile_px_t              w_b;
  logic                  w_sel_bg;
  logic [PRI_W-1:0]      w_win_pr;
  logic [COLOR_W-1:0]    w_win_cl;
  logic [DT_W-1:0]       w_win_dt;
  logic                  w_hb_rise;

  logic [PAL_ADDR_W-1:0] r_pal_addr;
  logic                  r_sel_bg;
  logic [PRI_W-1:0]      r_win_pr;
  logic                  r_blank;
  logic [COLOR_W-1:0]    r_dot;
  logic [PRI_W-1:0]      r_pro;
  logic [COLOR_W-1:0]    r_bg_pending;
  logic [COLOR_W-1:0]    r_bg_active;
  logic                  r_hblank_prev;

  assign w_a = '{pr: bus.A_PR, cl: bus.A_CL, dt: bus.A_DT};
  assign w_b = '{pr: bus.B_PR, cl: bus.B_CL, dt: bus.B_DT};

  tile_layer_select #(
    .DT_TRANSPARENT (DT_TRANSPARENT)
  ) u_select (
    .i_a      (w_a),
    .i_b      (w_b),
    .o_sel_bg (w_sel_bg),
    .o_win_pr (w_win_pr),
    .o_win_cl (w_win_cl),
    .o_win_dt (w_win_dt)
  );

  assign w_hb_rise = bus.HBLANK & ~r_hblank_prev;

  always_ff @(posedge CLK_6M) begin
    if (!rst) begin
      r_pal_addr    <= '0;
      r_sel_bg      <= 1'b0;
      r_win_pr      <= '0;
      r_blank       <= 1'b0;
      r_dot         <= '0;
      r_pro         <= '0;
      r_bg_pending  <= '0;
      r_bg_active   <= '0;
      r_hblank_prev <= 1'b0;
    end else begin
      // Stage 1. A fully transparent pixel leaves the PROM address untouched.
      if (!w_sel_bg) r_pal_addr <= {w_win_cl, w_win_dt};
      r_sel_bg <= w_sel_bg;
      r_win_pr <= w_win_pr;
      r_blank  <= bus.HBLANK | bus.VBLANK;

      // Stage 2. PAL_Q is the asynchronous PROM return of r_pal_addr.
      if (r_blank) begin
        r_dot <= BLANK_DOT;
        r_pro <= '0;
      end else if (r_sel_bg) begin
        r_dot <= r_bg_active;
        r_pro <= '0;
      end else begin
        r_dot <= bus.PAL_Q;
        r_pro <= r_win_pr;
      end

      // Background colour only switches at the start of horizontal blank so
      // a CPU write never splits a line; a write on that same edge goes straight through.
      r_hblank_prev <= bus.HBLANK;
      if (bus.BG_WE) r_bg_pending <= bus.BG_D;
      if (w_hb_rise) r_bg_active <= bus.BG_WE ? bus.BG_D : r_bg_pending;
    end
  end

  assign bus.PAL_ADDR = r_pal_addr;
  assign bus.DOT      = r_dot;
  assign bus.PRO      = r_pro;

endmodule

// File: doc/tile_priority_mixer.md
# tile_priority_mixer

Merges the two tile-layer pixel streams leaving the CUS43 tile generator chains (PR/CL/DT per layer) into one 8-bit colour index. It resolves per-pixel transparency and priority, drives the shared tile palette PROM (4V) address, and substitutes a CPU-latched background colour. It feeds the DOT input of the CLUT, on the CLK_6M pixel clock, between CUS43 and CLUT.

## Interface
Parameters:
- DT_TRANSPARENT, 3'd7, DT value marking a transparent tile pixel
- BLANK_DOT, 8'h00, DOT index driven during blanking

Ports:
- CLK_6M  in  1  pixel clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low; clock CLK_6M
- HBLANK  in  1  horizontal blank, active-high, aligned with layer inputs
- VBLANK  in  1  vertical blank, active-high, aligned with layer inputs
- A_PR  in  3  layer A priority
- A_CL  in  8  layer A colour
- A_DT  in  3  layer A dot
- B_PR  in  3  layer B priority
- B_CL  in  8  layer B colour
- B_DT  in  3  layer B dot
- PAL_ADDR  out  11  palette PROM address {CL,DT}, registered
- PAL_Q  in  8  palette PROM data, combinational return of PAL_ADDR
- BG_WE  in  1  background colour write strobe, 1-cycle pulse
- BG_D  in  8  background colour data
- DOT  out  8  final colour index to CLUT, registered
- PRO  out  3  priority of the winning pixel, for the sprite mixer; 0 for background or blank

## Operation
- Opaque test: a layer is opaque when its DT differs from DT_TRANSPARENT.
- Winner selection in stage 1:
  - both opaque: the higher PR wins; on equal PR, A wins.
  - only one opaque: that layer wins.
  - neither opaque: background is selected and PAL_ADDR holds its previous value.
- Stage 1 registers PAL_ADDR = {winner CL, winner DT}, a sel_bg flag, the winner PR, and blank = HBLANK|VBLANK.
- Stage 2 registers DOT and PRO:
  - blank=1: DOT=BLANK_DOT, PRO=0.
  - else sel_bg=1: DOT=bg_active, PRO=0.
  - else: DOT=PAL_Q, PRO=the registered winner PR.
- Background latch is two registers, bg_pending and bg_active.
  - A BG_WE pulse loads BG_D into bg_pending.
  - On the HBLANK rising edge (HBLANK=1 with the previous sample 0), bg_pending is copied into bg_active. A colour change therefore never tears mid-line.
  - If BG_WE and the HBLANK rising edge coincide, bg_active takes BG_D directly, and bg_pending also takes BG_D.

## Timing
- Latency is 2 cycles from layer inputs/blank to DOT/PRO. PAL_ADDR appears 1 cycle after its inputs.
- PAL_Q must be valid within the same cycle that PAL_ADDR is stable (asynchronous PROM model).
- Reset (rst=0 at an edge) clears PAL_ADDR, DOT, PRO, bg_pending, bg_active, the pipeline registers and the previous-HBLANK sample, all to 0. Reset wins over BG_WE in the same cycle.
- Reset in mid-line: DOT is 0 from the next edge. The first valid pixel appears 2 cycles after rst returns high.
- No stalls and no handshake: one pixel per cycle, every cycle.
- Blank edges propagate exactly 2 cycles, matching the pixel data.

## Structure
- The shared package system86_video_pkg holds:
  - DT_TRANSPARENT default
  - palette address width (11)
  - colour index width (8)
  - priority width (3)
- One natural sub-module: tile_layer_select, purely combinational. It takes two {PR,CL,DT} tuples and returns {sel_bg, win_pr, win_cl, win_dt}. It is reused later for the sprite/tile merge.
- Pipeline, background latch and HBLANK edge detect live in the top module.

## Test plan
- Reset: hold rst=0 with random inputs → DOT=0, PRO=0, PAL_ADDR=0. Release rst → the first pixel (A opaque, PR=2, CL=8'h12, DT=1, PAL_Q=8'h5A) gives DOT=8'h5A, PRO=2 two cycles later.
- Priority: A PR=3 DT=2 CL=8'h10; B PR=5 DT=4 CL=8'h20 → PAL_ADDR=11'h104, PRO=5. Swap to equal PR=4 → PAL_ADDR={8'h10,3'd2}, PRO=4.
- Transparency: A DT=7, B DT=0 CL=8'h33 → PAL_ADDR={8'h33,3'd0}. Then both DT=7 with bg_active=8'h44 → DOT=8'h44, PRO=0.
- Background latch: BG_WE with BG_D=8'hAB mid-line → DOT keeps the old background until the HBLANK rising edge. The first background pixel after HBLANK shows 8'hAB.
- Coincident write and HBLANK rising edge with BG_D=8'hC3 → bg_active=8'hC3 on that edge. BG_WE during rst=0 → bg_active stays 0.
- Blanking: VBLANK=1 with opaque layers → DOT=8'h00, PRO=0 exactly 2 cycles after VBLANK rises. DOT resumes 2 cycles after VBLANK falls.
